// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants and parity helper.
// Used by ps2_keyboard_tx and by the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } ps2_tx_state_t;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO in front of the PS/2 serializer; rst flushes it synchronously.
// DEPTH must be a power of two, at least 2.
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // storage write
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // pointer update with synchronous flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: serializes accepted bytes into 11-bit frames on ps2_clk/ps2_data.
// Define PS2_TX_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO in front of the serializer.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 4,
  parameter int GAP_HALVES = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int            CW        = $clog2(CLK_HALF + 1);
  localparam int            GW        = $clog2(GAP_HALVES + 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  if (CLK_HALF < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("ps2_keyboard_tx: CLK_HALF must be >= 1 and FIFO_DEPTH a power of two >= 2");
  end

  ps2_tx_state_t             state_r;
  ps2_tx_state_t             state_s;
  logic [CW-1:0]             half_cnt_r;
  logic [GW-1:0]             gap_cnt_r;
  logic [3:0]                bit_cnt_r;
  logic [PS2_FRAME_BITS-1:0] shift_r;
  logic                      ps2_clk_r;
  logic                      ps2_data_r;
  logic                      clk_s;
  logic                      data_s;
  logic                      half_done_s;
  logic                      start_s;
  logic                      avail_s;
  logic [7:0]                byte_s;

  assign half_done_s = (half_cnt_r == HALF_LAST);
  assign start_s     = (state_r == IDLE) && avail_s;

`ifdef PS2_TX_FIFO_EN
  logic full_s;
  logic empty_s;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (valid),
    .pop     (start_s),
    .wr_data (data),
    .rd_data (byte_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign avail_s = !empty_s;
  assign ready   = !full_s;
  assign busy    = !empty_s || (state_r != IDLE);
`else
  // Without a buffer the byte goes straight into the shift register on acceptance.
  assign avail_s = valid && ready;
  assign byte_s  = data;
  assign ready   = (state_r == IDLE) && !rst;
  assign busy    = (state_r != IDLE);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (avail_s) state_s = HIGH; else state_s = IDLE;
      HIGH: if (half_done_s) state_s = LOW; else state_s = HIGH;
      LOW: begin
        if (!half_done_s)                state_s = LOW;
        else if (bit_cnt_r != LAST_BIT)  state_s = HIGH;
        else if (GAP_HALVES == 0)        state_s = IDLE;
        else                             state_s = GAP;
      end
      GAP: if (half_done_s && gap_cnt_r == GAP_LAST) state_s = IDLE; else state_s = GAP;
      default: state_s = IDLE;
    endcase
  end

  // half-period/gap/bit counters and frame shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_r <= '0;
      gap_cnt_r  <= '0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= '1;
    end else begin
      if (state_r == IDLE || state_s != state_r || half_done_s) begin
        half_cnt_r <= '0;
      end else begin
        half_cnt_r <= half_cnt_r + CW'(1);
      end
      if (state_r != GAP) begin
        gap_cnt_r <= '0;
      end else if (half_done_s) begin
        gap_cnt_r <= gap_cnt_r + GW'(1);
      end
      if (start_s) begin
        shift_r   <= {PS2_STOP, ps2_odd_parity(byte_s), byte_s, PS2_START};
        bit_cnt_r <= 4'd0;
      end else if (state_r == LOW && state_s == HIGH) begin
        shift_r   <= {1'b1, shift_r[PS2_FRAME_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
    end
  end

  // pin values for the current state
  always_comb begin
    clk_s  = 1'b1;
    data_s = 1'b1;
    case (state_r)
      IDLE:    begin clk_s = 1'b1; data_s = 1'b1;       end
      HIGH:    begin clk_s = 1'b1; data_s = shift_r[0]; end
      LOW:     begin clk_s = 1'b0; data_s = shift_r[0]; end
      GAP:     begin clk_s = 1'b1; data_s = 1'b1;       end
      default: begin clk_s = 1'b1; data_s = 1'b1;       end
    endcase
  end

  // registered PS/2 pins; both idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
    end else begin
      ps2_clk_r  <= clk_s;
      ps2_data_r <= data_s;
    end
  end

  assign ps2_clk  = ps2_clk_r;
  assign ps2_data = ps2_data_r;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Scoreboard bench for ps2_keyboard_tx: accepted bytes are queued with their expected frame and
// a pin monitor decodes frames at ps2_clk falling edges. Honours PS2_TX_FIFO_EN.
module tb_ps2_keyboard_tx;

  localparam int CH    = 4;
  localparam int GH    = 2;
  localparam int LIMIT = 5000;
`ifdef PS2_TX_FIFO_EN
  localparam int START_LAT = CH + 2;
`else
  localparam int START_LAT = CH + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  ps2_keyboard_tx #(.CLK_HALF(CH), .GAP_HALVES(GH), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] b;
    int         acc;
    bit         from_idle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bitcnt = 0;
  int   stop_fall = 0;
  int   b2b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity from a ones count, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Pin monitor / scoreboard checker.
  initial begin : monitor
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    int          last_edge = 0;
    logic [10:0] got = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bitcnt = 0;
      end else begin
        if (ps2_data !== prev_data) chk("data_changes_only_with_clk_high", ps2_clk, 1);
        if (prev_clk && !ps2_clk) begin
          if (bitcnt == 0) begin
            chk("fall_only_when_frame_expected", exp_q.size() > 0, 1);
            b2b = cyc - stop_fall;
            if (exp_q.size() > 0 && exp_q[0].from_idle)
              chk("accept_to_first_fall", cyc - exp_q[0].acc, START_LAT);
          end else begin
            chk("high_half_width", cyc - last_edge, CH);
          end
          got[bitcnt] = ps2_data;
          bitcnt++;
          if (bitcnt == 11) begin
            stop_fall = cyc;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("frame_bits", got, model_frame(e.b));
            end
          end
          last_edge = cyc;
        end else if (!prev_clk && ps2_clk) begin
          if (bitcnt > 0) chk("low_half_width", cyc - last_edge, CH);
          if (bitcnt == 11) bitcnt = 0;
          last_edge = cyc;
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // Offer a byte and hold valid until accepted; caller and task sit just after a negedge.
  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    data  = b;
    valid = 1'b1;
    while (!ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      chk("ready_timeout", 0, 1);
      acc   = -1;
      valid = 1'b0;
    end else begin
      acc = cyc + 1;
      exp_q.push_back('{b: b, acc: acc, from_idle: (busy == 1'b0)});
      @(negedge clk);
      valid = 1'b0;
      data  = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy || bitcnt != 0) && n < LIMIT) begin
      @(negedge clk);
      data = 8'($urandom);
      n++;
    end
    chk("drain_in_time", n < LIMIT, 1);
    if (n >= LIMIT) exp_q.delete();
    idle(2);
  endtask

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] dir_bytes [5];
    int acc1, acc2, n;
    int acc9 [9];

    dir_bytes[0] = 8'h1C; dir_bytes[1] = 8'h00; dir_bytes[2] = 8'hFF;
    dir_bytes[3] = 8'hF0; dir_bytes[4] = 8'h01;
    rst = 1'b1; valid = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ps2_clk", ps2_clk, 1);
    chk("reset_ps2_data", ps2_data, 1);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);

    // single frames and parity cases
    foreach (dir_bytes[i]) begin
      send(dir_bytes[i], acc1);
      drain();
    end

    // break sequence with valid held
    send(8'hF0, acc1);
    send(8'h1C, acc2);
`ifndef PS2_TX_FIFO_EN
    chk("ready_low_span", acc2 - acc1, 22 * CH + GH * CH + 1);
`endif
    drain();
    chk("back_to_back_stop_to_start", b2b, 2 * CH + GH * CH + 1);

    // nine bytes on consecutive cycles
    for (int i = 0; i < 9; i++) send(8'(8'h30 + i), acc9[i]);
`ifdef PS2_TX_FIFO_EN
    chk("fifo_pushes_consecutive", acc9[8] - acc9[0], 8);
    chk("fifo_full_ready_low", ready, 0);
`endif
    drain();

    // reset during bit 4
    send(8'h33, acc1);
`ifdef PS2_TX_FIFO_EN
    send(8'h44, acc1);
    send(8'h55, acc1);
`endif
    n = 0;
    while (bitcnt < 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit4", n < LIMIT, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_ps2_clk", ps2_clk, 1);
    chk("midreset_ps2_data", ps2_data, 1);
    chk("midreset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(150);
    chk("no_resume_after_reset", busy, 0);
    send(8'h5A, acc1);
    drain();

    // randomized bytes, gaps and data scrambling
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) idle($urandom_range(40, 1));
      send(8'($urandom), acc1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
